// File: rtl/decode_stage_sb.sv
// decode_stage_sb: registered IITB-RISC decode stage with a valid/ready
// handshake and a register scoreboard. It stalls fetch while a source or
// destination register is still waiting for writeback.
module decode_stage_sb #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16,
    parameter int REG_AW = ($clog2(NREGS) < 3) ? 3 : $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic              out_rd_en,
    output logic              out_rs1_en,
    output logic              out_rs2_en,
    output logic [1:0]        out_cz,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  pending,
    output logic [CNT_W-1:0]  hazard_cnt
);

    logic [3:0]        dec_opcode;
    logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
    logic              dec_rd_en, dec_rs1_en, dec_rs2_en;
    logic [1:0]        dec_cz;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;

    logic [REG_AW-1:0] fld_a, fld_b, fld_c;
    logic [DATA_W-1:0] imm_s6, imm_s9, imm_lhi;

    logic              hazard;
    logic              accept;
    logic [NREGS-1:0]  pending_nxt;

    assign fld_a   = REG_AW'(in_instr[11:9]);
    assign fld_b   = REG_AW'(in_instr[8:6]);
    assign fld_c   = REG_AW'(in_instr[5:3]);
    assign imm_s6  = DATA_W'($signed(in_instr[5:0]));
    assign imm_s9  = DATA_W'($signed(in_instr[8:0]));
    assign imm_lhi = DATA_W'({in_instr[8:0], 7'b0});

    // Decode the incoming word; unused fields and enables stay at zero.
    always_comb begin
        dec_opcode  = in_instr[15:12];
        dec_rd      = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd_en   = 1'b0;
        dec_rs1_en  = 1'b0;
        dec_rs2_en  = 1'b0;
        dec_cz      = 2'b00;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (in_instr[15:12])
            4'h0: begin
                dec_rs1 = fld_a; dec_rs1_en = 1'b1;
                dec_rd  = fld_b; dec_rd_en  = 1'b1;
                dec_imm = imm_s6;
            end
            4'h1, 4'h2: begin
                dec_rs1 = fld_a; dec_rs1_en = 1'b1;
                dec_rs2 = fld_b; dec_rs2_en = 1'b1;
                dec_rd  = fld_c; dec_rd_en  = 1'b1;
                dec_cz  = in_instr[1:0];
            end
            4'h3: begin
                dec_rd  = fld_a; dec_rd_en = 1'b1;
                dec_imm = imm_lhi;
            end
            4'h4: begin
                dec_rd  = fld_a; dec_rd_en  = 1'b1;
                dec_rs1 = fld_b; dec_rs1_en = 1'b1;
                dec_imm = imm_s6;
            end
            4'h5, 4'h8: begin
                dec_rs1 = fld_a; dec_rs1_en = 1'b1;
                dec_rs2 = fld_b; dec_rs2_en = 1'b1;
                dec_imm = imm_s6;
            end
            4'h9: begin
                dec_rd  = fld_a; dec_rd_en = 1'b1;
                dec_imm = imm_s9;
            end
            4'hA: begin
                dec_rd  = fld_a; dec_rd_en  = 1'b1;
                dec_rs1 = fld_b; dec_rs1_en = 1'b1;
            end
            4'hB: begin
                dec_rs1 = fld_a; dec_rs1_en = 1'b1;
                dec_imm = imm_s9;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign hazard = in_valid & ((dec_rs1_en & pending[dec_rs1]) |
                                (dec_rs2_en & pending[dec_rs2]) |
                                (dec_rd_en  & pending[dec_rd]));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Scoreboard next state: clears first, then the new destination is marked busy.
    always_comb begin
        pending_nxt = pending;
        if (flush && out_valid && out_rd_en) begin
            pending_nxt[out_rd] = 1'b0;
        end
        if (wb_valid) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (accept && dec_rd_en) begin
            pending_nxt[dec_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Output register: flush beats accept, accept beats consume, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd_en   <= 1'b0;
            out_rs1_en  <= 1'b0;
            out_rs2_en  <= 1'b0;
            out_cz      <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_opcode  <= dec_opcode;
            out_rd      <= dec_rd;
            out_rs1     <= dec_rs1;
            out_rs2     <= dec_rs2;
            out_rd_en   <= dec_rd_en;
            out_rs1_en  <= dec_rs1_en;
            out_rs2_en  <= dec_rs2_en;
            out_cz      <= dec_cz;
            out_imm     <= dec_imm;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles spent stalled on a register hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_cnt <= '0;
        end else if (hazard && (hazard_cnt != {CNT_W{1'b1}})) begin
            hazard_cnt <= hazard_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_sb.sv
// tb_decode_stage_sb: decode table vectors, hand-written handshake/hazard
// sequences and a randomized run against a behavioural scoreboard model.
module tb_decode_stage_sb;

    localparam int DW     = 16;
    localparam int NR     = 8;
    localparam int CW     = 4;
    localparam int AW     = 3;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        rd_en;
        logic        rs1_en;
        logic        rs2_en;
        logic [1:0]  cz;
        logic [15:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [15:0] instr;
        dec_t        exp;
    } vec_t;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [15:0]   in_instr;
    logic [3:0]    out_opcode;
    logic [AW-1:0] out_rd, out_rs1, out_rs2, wb_rd;
    logic          out_rd_en, out_rs1_en, out_rs2_en, out_illegal;
    logic [1:0]    out_cz;
    logic [DW-1:0] out_imm;
    logic          wb_valid, flush;
    logic [NR-1:0] pending;
    logic [CW-1:0] hazard_cnt;
    dec_t          dut_entry;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NR-1:0] m_pend;
    bit            m_valid;
    dec_t          m_entry;
    int            m_cnt;

    decode_stage_sb #(.DATA_W(DW), .NREGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_en(out_rd_en), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_cz(out_cz), .out_imm(out_imm), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .pending(pending), .hazard_cnt(hazard_cnt)
    );

    assign dut_entry = {out_opcode, out_rd, out_rs1, out_rs2, out_rd_en, out_rs1_en,
                        out_rs2_en, out_cz, out_imm, out_illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a hung handshake can never stall the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decode rule table evaluated with plain integer arithmetic.
    function automatic dec_t modelDecode(input logic [15:0] ins);
        dec_t d;
        int a, b, c, s6, s9;
        d  = '0;
        d.op = ins[15:12];
        a  = int'(ins[11:9]);
        b  = int'(ins[8:6]);
        c  = int'(ins[5:3]);
        s6 = int'(ins[5:0]);
        if (s6 >= 32) s6 = s6 - 64;
        s9 = int'(ins[8:0]);
        if (s9 >= 256) s9 = s9 - 512;
        case (int'(ins[15:12]))
            0:     begin d.rs1 = 3'(a); d.rs1_en = 1; d.rd = 3'(b); d.rd_en = 1; d.imm = 16'(s6); end
            1, 2:  begin d.rs1 = 3'(a); d.rs1_en = 1; d.rs2 = 3'(b); d.rs2_en = 1;
                         d.rd = 3'(c); d.rd_en = 1; d.cz = ins[1:0]; end
            3:     begin d.rd = 3'(a); d.rd_en = 1; d.imm = 16'(int'(ins[8:0]) * 128); end
            4:     begin d.rd = 3'(a); d.rd_en = 1; d.rs1 = 3'(b); d.rs1_en = 1; d.imm = 16'(s6); end
            5, 8:  begin d.rs1 = 3'(a); d.rs1_en = 1; d.rs2 = 3'(b); d.rs2_en = 1; d.imm = 16'(s6); end
            9:     begin d.rd = 3'(a); d.rd_en = 1; d.imm = 16'(s9); end
            10:    begin d.rd = 3'(a); d.rd_en = 1; d.rs1 = 3'(b); d.rs1_en = 1; end
            11:    begin d.rs1 = 3'(a); d.rs1_en = 1; d.imm = 16'(s9); end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic vec_t mk(input logic [15:0] ins, input logic [3:0] op,
                                input int rd, input int rs1, input int rs2,
                                input bit rde, input bit r1e, input bit r2e,
                                input int cz, input logic [15:0] imm, input bit ill);
        vec_t v;
        v.instr = ins;
        v.exp   = '{op: op, rd: 3'(rd), rs1: 3'(rs1), rs2: 3'(rs2), rd_en: rde,
                    rs1_en: r1e, rs2_en: r2e, cz: 2'(cz), imm: imm, ill: ill};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [15:0] ins, input bit ordy,
                                 input bit wbv, input logic [AW-1:0] wbr, input bit fl);
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wbv;
        wb_rd     = wbr;
        flush     = fl;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle: check the combinational handshake, advance the model, check state.
    task automatic randomCycle();
        dec_t d;
        bit   haz, rdy, acc;
        applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 19) == 0);
        d   = modelDecode(in_instr);
        haz = in_valid && ((d.rs1_en && m_pend[d.rs1]) || (d.rs2_en && m_pend[d.rs2]) ||
                           (d.rd_en && m_pend[d.rd]));
        rdy = !flush && !haz && (!m_valid || out_ready);
        acc = in_valid && rdy;
        checkOutput("rand_in_ready", in_ready, rdy);
        if (haz && m_cnt < CNTMAX) m_cnt++;
        if (flush) begin
            if (m_valid && m_entry.rd_en) m_pend[m_entry.rd] = 1'b0;
            m_valid = 0;
        end else if (acc) begin
            m_entry = d;
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (wb_valid) m_pend[wb_rd] = 1'b0;
        if (acc && d.rd_en) m_pend[d.rd] = 1'b1;
        waitEdge();
        checkOutput("rand_out_valid", out_valid, m_valid);
        checkOutput("rand_pending", pending, m_pend);
        checkOutput("rand_hazard_cnt", hazard_cnt, m_cnt);
        if (m_valid) checkOutput("rand_entry", dut_entry, m_entry);
    endtask

    vec_t vecs[12];

    initial begin
        rst_n = 1'b1;
        in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;

        vecs[0]  = mk(16'h1298, 4'h1, 3, 1, 2, 1, 1, 1, 0, 16'h0000, 0);
        vecs[1]  = mk(16'h4800, 4'h4, 4, 0, 0, 1, 1, 0, 0, 16'h0000, 0);
        vecs[2]  = mk(16'h9FFF, 4'h9, 7, 0, 0, 1, 0, 0, 0, 16'hFFFF, 0);
        vecs[3]  = mk(16'h31FF, 4'h3, 0, 0, 0, 1, 0, 0, 0, 16'hFF80, 0);
        vecs[4]  = mk(16'hF000, 4'hF, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);
        vecs[5]  = mk(16'h0760, 4'h0, 5, 3, 0, 1, 1, 0, 0, 16'hFFE0, 0);
        vecs[6]  = mk(16'h5A7F, 4'h5, 0, 5, 1, 0, 1, 1, 0, 16'hFFFF, 0);
        vecs[7]  = mk(16'h8A45, 4'h8, 0, 5, 1, 0, 1, 1, 0, 16'h0005, 0);
        vecs[8]  = mk(16'hA6C0, 4'hA, 3, 3, 0, 1, 1, 0, 0, 16'h0000, 0);
        vecs[9]  = mk(16'hB0FF, 4'hB, 0, 0, 0, 0, 1, 0, 0, 16'h00FF, 0);
        vecs[10] = mk(16'h2A5B, 4'h2, 3, 5, 1, 1, 1, 1, 3, 16'h0000, 0);
        vecs[11] = mk(16'h6123, 4'h6, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);

        // Reset state.
        resetDut();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_hazard_cnt", hazard_cnt, 0);
        checkOutput("reset_entry", dut_entry, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Decode table: one accepted instruction from a clean scoreboard each.
        for (int i = 0; i < 12; i++) begin
            resetDut();
            applyStimulus(1, vecs[i].instr, 1, 0, '0, 0);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1);
            waitEdge();
            checkOutput($sformatf("vec%0d_out_valid", i), out_valid, 1);
            checkOutput($sformatf("vec%0d_entry", i), dut_entry, vecs[i].exp);
            checkOutput($sformatf("vec%0d_pending", i), pending,
                        vecs[i].exp.rd_en ? (8'h01 << vecs[i].exp.rd) : 8'h00);
        end

        // LW R4 then ADD reading R4: stall until the writeback clear has registered.
        resetDut();
        applyStimulus(1, 16'h4800, 1, 0, '0, 0);
        waitEdge();
        checkOutput("raw_pending_lw", pending, 8'h10);
        applyStimulus(1, 16'h1808, 1, 0, '0, 0);
        checkOutput("raw_stall_in_ready", in_ready, 0);
        waitEdge();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("raw_hazard_cnt3", hazard_cnt, 3);
        checkOutput("raw_out_valid_drained", out_valid, 0);
        applyStimulus(1, 16'h1808, 1, 1, 3'd4, 0);
        checkOutput("raw_no_bypass", in_ready, 0);
        waitEdge();
        checkOutput("raw_pending_cleared", pending, 8'h00);
        checkOutput("raw_hazard_cnt4", hazard_cnt, 4);
        applyStimulus(1, 16'h1808, 1, 0, '0, 0);
        checkOutput("raw_release_in_ready", in_ready, 1);
        waitEdge();
        checkOutput("raw_add_valid", out_valid, 1);
        checkOutput("raw_add_rs1", out_rs1, 4);
        checkOutput("raw_add_pending", pending, 8'h02);

        // Same ADD again is a WAW on R1: count saturates while stalled.
        applyStimulus(1, 16'h1808, 1, 0, '0, 0);
        checkOutput("waw_in_ready", in_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("cnt_saturate", hazard_cnt, CNTMAX);

        // Asynchronous reset mid-stall, away from any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_pending", pending, 0);
        checkOutput("async_rst_hazard_cnt", hazard_cnt, 0);
        checkOutput("async_rst_entry", dut_entry, 0);
        rst_n = 1'b1;

        // Backpressure: entry holds, no duplicate, one transfer on release.
        resetDut();
        applyStimulus(1, 16'h1298, 1, 0, '0, 0);
        waitEdge();
        checkOutput("bp_first_valid", out_valid, 1);
        applyStimulus(1, 16'h8A45, 0, 0, '0, 0);
        checkOutput("bp_in_ready_low", in_ready, 0);
        waitEdge();
        waitEdge();
        checkOutput("bp_hold_valid", out_valid, 1);
        checkOutput("bp_hold_entry", dut_entry, vecs[0].exp);
        applyStimulus(1, 16'h8A45, 1, 0, '0, 0);
        checkOutput("bp_release_in_ready", in_ready, 1);
        waitEdge();
        checkOutput("bp_next_entry", dut_entry, vecs[7].exp);
        checkOutput("bp_pending", pending, 8'h08);
        applyStimulus(0, 16'h0000, 1, 0, '0, 0);
        waitEdge();
        checkOutput("bp_drained", out_valid, 0);

        // Flush drops ADI R5 and releases its scoreboard bit.
        resetDut();
        applyStimulus(1, 16'h0140, 1, 0, '0, 0);
        waitEdge();
        checkOutput("flush_pre_pending", pending, 8'h20);
        checkOutput("flush_pre_rd", out_rd, 5);
        applyStimulus(1, 16'h1298, 0, 0, '0, 1);
        checkOutput("flush_in_ready", in_ready, 0);
        waitEdge();
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_pending", pending, 8'h00);

        // Randomized run against the behavioural model.
        resetDut();
        m_pend = '0; m_valid = 0; m_entry = '0; m_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            randomCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
